uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal transmit FIFO and configurable frame format: word length, parity mode and stop-bit count. It sits between the switch/host data source and the UART pin. It accepts words over a valid/ready handshake and serialises them back to back. It exports state, bit-index and FIFO-level debug outputs for the seven-segment and LED status logic.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD_RATE (integer divide, must be >= 2)
Word_Len, 8, data bits per frame, legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, 1 or 2
FIFO_DEPTH, 8, FIFO entries, power of two, >= 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
tx_data_in  input  Word_Len  word to transmit, LSB sent first
tx_data_valid  input  1  tx_data_in is valid this cycle
tx_data_ready  output  1  FIFO can accept a word (not full)
Uart_Tx  output  1  serial line, idle high
tx_busy  output  1  frame in progress or FIFO non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently held in the FIFO
current_state_out  output  3  FSM state code
bit_counter_out  output  6  index of the data bit currently on the line

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Uart_Tx=1, state=Idle, FIFO emptied.
  - fifo_count=0, tx_data_ready=1, tx_busy=0, bit_counter_out=0, baud counter=0.
  - Reset mid-frame aborts the frame; the line returns high with no glitch low.
- Push: word written at a rising edge when tx_data_valid && tx_data_ready.
  - tx_data_ready = (fifo_count != FIFO_DEPTH), registered-state derived.
  - A push while full is impossible by handshake; a pop in the same cycle does not make a full FIFO accept.
- Pop: the FSM pops the head word when in Idle with FIFO non-empty, or at the last cycle of the final stop bit with FIFO non-empty.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - A word written into an empty FIFO is poppable on the next cycle.
- Latency: word accepted at edge T with the FSM Idle and the FIFO empty → Uart_Tx low from edge T+2.
- State codes: Idle=3'd0, Start=3'd1, Data=3'd2, Stop=3'd3, Parity=3'd4.
- Bit timing: every bit (start, data, parity, stop) holds Uart_Tx for exactly BAUD_DIV clocks. The baud counter counts 0..BAUD_DIV-1 and restarts on each state/bit change.
- Transitions:
  - Idle→Start on pop; the popped word is latched into a shift register and parity is computed from it.
  - Start (line 0)→Data after BAUD_DIV cycles.
  - Data sends bit i for i=0..Word_Len-1; after the last bit go to Parity if PARITY_MODE!=0, else to Stop.
  - Parity drives the odd parity bit (XNOR-reduce of the word) or the even parity bit (XOR-reduce), then goes to Stop.
  - Stop holds the line at 1 for STOP_BITS×BAUD_DIV cycles. At its final cycle: if the FIFO is non-empty, pop and go directly to Start (contiguous frames, zero idle cycles); else go to Idle.
- bit_counter_out: current data-bit index in Data; Word_Len in Parity; 0 in every other state.
- tx_busy = (state != Idle) || (fifo_count != 0).
- Frame length = (1 + Word_Len + (PARITY_MODE!=0) + STOP_BITS) × BAUD_DIV clocks.
- PARITY_MODE value 3 behaves as none.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count saturates at neither end; the handshake prevents overflow, and pops occur only when non-empty.

Test Plan:
1. CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BAUD_DIV=10), Word_Len=8, no parity, 1 stop bit; push 8'hA5 while idle → Uart_Tx low from T+2 for 10 cycles, then 1,0,1,0,0,1,0,1 (10 cycles each), then high for 10. Frame is 100 cycles; tx_busy then falls.
2. Same word with PARITY_MODE=2 → parity bit 0, frame 110 cycles. With PARITY_MODE=1 → parity bit 1. bit_counter_out=8 during the parity bit.
3. STOP_BITS=2, Word_Len=5; push 5'h1F → line high for 20 cycles after bit 4, frame 80 cycles.
4. FIFO_DEPTH=4; hold valid and push 6 words while idle → tx_data_ready drops after the 5th accepted word (one popped immediately). fifo_count peaks at 4, and all 5 frames are sent contiguously with no idle cycle between stop and the next start.
5. Simultaneous push/pop: push exactly at the final stop cycle with 2 words queued → fifo_count stays 2 and the next Start begins on the following cycle.
6. Assert reset during data bit 3 → Uart_Tx=1 and state=0 immediately (before the next edge), fifo_count=0. After release, a new push transmits a clean frame.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Function : UART transmitter with a transmit FIFO, configurable word length,
//            parity and stop bits, and state/bit/level debug outputs.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int Word_Len    = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [Word_Len-1:0]           tx_data_in,
    input  logic                          tx_data_valid,
    output logic                          tx_data_ready,
    output logic                          Uart_Tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    current_state_out,
    output logic [5:0]                    bit_counter_out
);

    localparam int c_BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int c_BAUD_W   = (c_BAUD_DIV > 2) ? $clog2(c_BAUD_DIV) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_BAUD_DIV - 1);
    localparam int c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam bit c_HAS_PARITY = (PARITY_MODE == 1) || (PARITY_MODE == 2);
    localparam logic [5:0] c_LAST_DATA = 6'(Word_Len - 1);
    localparam logic [5:0] c_LAST_STOP = 6'(STOP_BITS - 1);
    localparam logic [5:0] c_WORD_LEN  = 6'(Word_Len);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_t;

    state_t                r_state;
    logic [c_BAUD_W-1:0]   r_baud;
    logic [5:0]            r_bit_idx;
    logic [Word_Len-1:0]   r_shift;
    logic                  r_parity;
    logic                  r_tx;

    logic [Word_Len-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_bit_end;
    logic                  w_stop_last;
    logic                  w_line;
    logic [Word_Len-1:0]   w_head;
    logic                  w_head_parity;

    assign tx_data_ready = (r_count != c_FULL);
    assign w_push        = tx_data_valid && tx_data_ready;
    assign w_bit_end     = (r_baud == c_BAUD_LAST);
    assign w_stop_last   = (r_state == S_STOP) && w_bit_end && (r_bit_idx == c_LAST_STOP);
    assign w_pop         = (r_count != '0) && ((r_state == S_IDLE) || w_stop_last);
    assign w_head        = r_mem[r_rd_ptr];
    assign w_head_parity = (PARITY_MODE == 1) ? ~^w_head : ^w_head;

    // FIFO storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_line = 1'b1;
        case (r_state)
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = r_shift[0];
            S_PARITY: w_line = r_parity;
            default:  w_line = 1'b1;
        endcase
    end

    // The line is a registered copy of the state-derived level, so it trails
    // the state by one clock and is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_tx <= w_line;
            case (r_state)
                S_IDLE: begin
                    r_baud    <= '0;
                    r_bit_idx <= '0;
                    if (w_pop) begin
                        r_shift  <= w_head;
                        r_parity <= w_head_parity;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == c_LAST_DATA) begin
                            r_bit_idx <= '0;
                            r_state   <= c_HAS_PARITY ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == c_LAST_STOP) begin
                            r_bit_idx <= '0;
                            if (w_pop) begin
                                r_shift  <= w_head;
                                r_parity <= w_head_parity;
                                r_state  <= S_START;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_baud    <= '0;
                    r_bit_idx <= '0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign Uart_Tx           = r_tx;
    assign tx_busy           = (r_state != S_IDLE) || (r_count != '0);
    assign fifo_count        = r_count;
    assign current_state_out = r_state;
    assign bit_counter_out   = (r_state == S_DATA)   ? r_bit_idx  :
                               (r_state == S_PARITY) ? c_WORD_LEN : 6'd0;

endmodule
`default_nettype wire
